// File: rtl/j1_io_pkg.sv
// ============================================================================
// j1_io_pkg: register offsets, STAT bit positions and FSM states of wb_uart.
// Rev 1.0
// ============================================================================
`default_nettype none

package j1_io_pkg;

   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_STAT = 2'd1,
      REG_DIV  = 2'd2,
      REG_CTRL = 2'd3
   } uart_reg_e;

   localparam int STAT_RX_VALID = 0;
   localparam int STAT_RX_FULL  = 1;
   localparam int STAT_TX_FULL  = 2;
   localparam int STAT_TX_IDLE  = 3;
   localparam int STAT_OVERRUN  = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// uart_fifo: synchronous show-ahead FIFO, power-of-2 depth, count-based flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              do_push, do_pop;

   assign o_full  = (count_q == CNT_FULL);
   assign o_empty = (count_q == '0);
   assign o_count = count_q;
   assign o_dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = i_push & ~o_full;
      do_pop   = i_pop & ~o_empty;
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the count alone defines valid entries.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_uart.sv
// ============================================================================
// wb_uart: Wishbone classic slave 8N1 UART with TX/RX FIFOs and 16x divisor.
// Optional internal loopback via macro WB_UART_LOOPBACK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_uart #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd26
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_ni,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [2:0]  wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic        uart_rxd_i,
   output logic        uart_txd_o,
   output logic        irq_o
);
   import j1_io_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        ack_q, ack_d, ovr_q, ovr_d, rx_ie_q, rx_ie_d, lb;
   logic [15:0] dat_q, dat_d, div_q, div_d, tcnt_q, tcnt_d, stat;
   logic        wb_req, tick, tx_push, rx_pop, ovr_clr, ovr_set, adr_unused;
   uart_reg_e   reg_sel;

   logic          tx_full, tx_empty, tx_pop, tx_idle, txd_int, tx_bit_end;
   logic [7:0]    tx_dout, tx_sh_q, tx_sh_d;
   logic [CW-1:0] tx_count, rx_count;
   logic [3:0]    tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   tx_state_e     tx_state_q, tx_state_d;

   logic          rx_full, rx_empty, rx_push, rx_src, rx_s, rx_bit_end, rx_mid;
   logic          sync1_q, sync2_q, last_q;
   logic [7:0]    rx_dout, rx_sh_q, rx_sh_d;
   rx_state_e     rx_state_q, rx_state_d;

   assign adr_unused = wb_adr_i[0];
   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign tx_idle    = (tx_state_q == TX_IDLE) && (tx_count == '0);
   assign irq_o      = (rx_count != '0) & rx_ie_q;
   assign rx_s       = sync2_q;

`ifdef WB_UART_LOOPBACK_EN
   logic lb_q, lb_d;
   assign lb         = lb_q;
   assign uart_txd_o = lb_q ? 1'b1 : txd_int;
   assign rx_src     = lb_q ? txd_int : uart_rxd_i;
`else
   assign lb         = 1'b0;
   assign uart_txd_o = txd_int;
   assign rx_src     = uart_rxd_i;
`endif

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(sys_clk_i), .rst_n(sys_rst_ni), .i_push(tx_push), .i_din(wb_dat_i[7:0]),
      .i_pop(tx_pop), .o_dout(tx_dout), .o_full(tx_full), .o_empty(tx_empty), .o_count(tx_count)
   );

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(sys_clk_i), .rst_n(sys_rst_ni), .i_push(rx_push), .i_din(rx_sh_q),
      .i_pop(rx_pop), .o_dout(rx_dout), .o_full(rx_full), .o_empty(rx_empty), .o_count(rx_count)
   );

   // Bus decode: the access and its single side effect happen in the request cycle.
   always_comb begin
      wb_req  = wb_cyc_i & wb_stb_i & ~ack_q;
      reg_sel = uart_reg_e'(wb_adr_i[2:1]);
      ack_d   = wb_req;
      dat_d   = '0;
      div_d   = div_q;
      rx_ie_d = rx_ie_q;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      ovr_clr = 1'b0;
`ifdef WB_UART_LOOPBACK_EN
      lb_d    = lb_q;
`endif
      stat                = '0;
      stat[STAT_RX_VALID] = (rx_count != '0);
      stat[STAT_RX_FULL]  = rx_full;
      stat[STAT_TX_FULL]  = tx_full;
      stat[STAT_TX_IDLE]  = tx_idle;
      stat[STAT_OVERRUN]  = ovr_q;
      if (wb_req && wb_we_i) begin
         case (reg_sel)
            REG_DATA: tx_push = 1'b1;
            REG_STAT: ovr_clr = wb_dat_i[STAT_OVERRUN];
            REG_DIV:  div_d   = wb_dat_i;
            default: begin
               rx_ie_d = wb_dat_i[0];
`ifdef WB_UART_LOOPBACK_EN
               lb_d    = wb_dat_i[1];
`endif
            end
         endcase
      end else if (wb_req) begin
         case (reg_sel)
            REG_DATA: begin
               rx_pop = 1'b1;
               dat_d  = rx_empty ? 16'h0000 : {8'h00, rx_dout};
            end
            REG_STAT: dat_d = stat;
            REG_DIV:  dat_d = div_q;
            default:  dat_d = {14'h0, lb, rx_ie_q};
         endcase
      end
      ovr_d = ovr_clr ? 1'b0 : ovr_q;
      if (ovr_set) begin
         ovr_d = 1'b1;
      end
   end

   // Tick generator and transmitter.
   always_comb begin
      tick       = (tcnt_q == 16'd0);
      tcnt_d     = tick ? div_q : tcnt_q - 16'd1;
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      tx_bit_end = tick && (tx_tcnt_q == 4'd15);
      txd_int    = 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_dout;
               tx_tcnt_d  = 4'd0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            txd_int = 1'b0;
            if (tx_bit_end) begin
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            txd_int = tx_sh_q[0];
            if (tx_bit_end) begin
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end
            end
         end
         default: begin
            // Chain straight into the next START so queued bytes go out back-to-back.
            if (tx_bit_end) begin
               tx_state_d = TX_IDLE;
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_sh_d    = tx_dout;
                  tx_state_d = TX_START;
               end
            end
         end
      endcase
   end

   // Receiver: start is validated at mid-bit, later samples fall 16 ticks apart.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_tcnt_d  = tick ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_push    = 1'b0;
      ovr_set    = 1'b0;
      rx_bit_end = tick && (rx_tcnt_q == 4'd15);
      rx_mid     = tick && (rx_tcnt_q == 4'd7);
      case (rx_state_q)
         RX_IDLE: begin
            if (last_q && !rx_s) begin
               rx_tcnt_d  = 4'd0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_mid) begin
               rx_tcnt_d  = 4'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end
         end
         default: begin
            if (rx_bit_end) begin
               rx_state_d = RX_IDLE;
               if (rx_s) begin
                  rx_push = ~rx_full;
                  ovr_set = rx_full;
               end
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         div_q      <= DIV_RESET;
         tcnt_q     <= '0;
         rx_ie_q    <= 1'b0;
         ovr_q      <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_tcnt_q  <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         last_q     <= 1'b1;
`ifdef WB_UART_LOOPBACK_EN
         lb_q       <= 1'b0;
`endif
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         div_q      <= div_d;
         tcnt_q     <= tcnt_d;
         rx_ie_q    <= rx_ie_d;
         ovr_q      <= ovr_d;
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         sync1_q    <= rx_src;
         sync2_q    <= sync1_q;
         last_q     <= sync2_q;
`ifdef WB_UART_LOOPBACK_EN
         lb_q       <= lb_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_uart.sv
// ============================================================================
// tb_wb_uart: randomized scoreboard bench for wb_uart (bus reads and TX line).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_uart;

   localparam int DEPTH = 16;
   localparam logic [2:0] A_DATA = 3'd0, A_STAT = 3'd2, A_DIV = 3'd4, A_CTRL = 3'd6;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [2:0]  wb_adr = '0;
   logic [15:0] wb_dat = '0, wb_dat_o;
   logic        wb_ack_o, rxd = 1'b1, uart_txd_o, irq_o;

   always #5 clk = ~clk;

   wb_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd26)) dut (
      .sys_clk_i(clk), .sys_rst_ni(rst_n), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
      .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .uart_rxd_i(rxd), .uart_txd_o(uart_txd_o), .irq_o(irq_o)
   );

   int total = 0, bad = 0, cur_div = 26, tx_frames = 0;
   logic [15:0] rd_exp_q[$], rd_mask_q[$];
   int          rd_adr_q[$];
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_model[$];
   bit          rx_ovr = 1'b0;

   task automatic check(input string name, input int got, input int req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   task automatic fail(input string name, input int got, input int req);
      total++;
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
   endtask

   task automatic bus(input bit we, input logic [2:0] adr, input logic [15:0] dat);
      int lat = -1;
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wb_ack_o === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) fail("ack_timeout", lat, 0);
      else check("ack_latency", lat, 0);
      #1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk);
      check("ack_drop", int'(wb_ack_o), 0);
   endtask

   task automatic wr(input logic [2:0] adr, input logic [15:0] dat);
      bus(1'b1, adr, dat);
   endtask

   task automatic rd(input logic [2:0] adr, input logic [15:0] exp, input logic [15:0] mask);
      rd_exp_q.push_back(exp);
      rd_mask_q.push_back(mask);
      rd_adr_q.push_back(int'(adr));
      bus(1'b0, adr, 16'h0);
   endtask

   function automatic logic [15:0] rx_stat();
      logic [15:0] s = '0;
      s[0] = rx_model.size() != 0;
      s[1] = rx_model.size() == DEPTH;
      s[4] = rx_ovr;
      return s;
   endfunction

   task automatic rd_data();
      logic [15:0] e = 16'h0;
      if (rx_model.size() != 0) e = {8'h00, rx_model.pop_front()};
      rd(A_DATA, e, 16'hFFFF);
   endtask

   task automatic set_div(input int d);
      wr(A_DIV, 16'(d));
      rd(A_DIV, 16'(d), 16'hFFFF);
      cur_div = d;
      repeat (40) @(negedge clk);
   endtask

   task automatic tx_byte(input logic [7:0] b);
      wr(A_DATA, {8'h00, b});
      tx_exp.push_back(b);
   endtask

   task automatic rx_send(input logic [7:0] b, input bit stop);
      int bp = 16 * (cur_div + 1);
      rxd = 1'b0;
      repeat (bp) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bp) @(negedge clk);
      end
      rxd = stop;
      repeat (bp) @(negedge clk);
      rxd = 1'b1;
      repeat (bp) @(negedge clk);
      if (stop) begin
         if (rx_model.size() < DEPTH) rx_model.push_back(b);
         else rx_ovr = 1'b1;
      end
   endtask

   task automatic wait_tx_done(input int budget);
      int n = 0;
      while (tx_exp.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("tx_drain_pending", tx_exp.size(), 0);
      repeat (16 * (cur_div + 1)) @(negedge clk);
   endtask

   // Bus read scoreboard.
   logic [15:0] m_exp, m_mask;
   int          m_adr;
   always @(negedge clk) begin
      if (wb_ack_o === 1'b1 && wb_we === 1'b0 && wb_cyc === 1'b1) begin
         if (rd_exp_q.size() == 0) begin
            fail("rd_unexpected", int'(wb_dat_o), 0);
         end else begin
            m_exp = rd_exp_q.pop_front();
            m_mask = rd_mask_q.pop_front();
            m_adr = rd_adr_q.pop_front();
            total++;
            if ((wb_dat_o & m_mask) !== (m_exp & m_mask)) begin
               bad++;
               $display("FAIL rd adr=%0d got=%h required=%h mask=%h", m_adr, wb_dat_o, m_exp, m_mask);
            end
         end
      end
   end

   // TX line monitor: decodes frames at mid-bit and compares with the expected queue.
   int          t_bp;
   logic [7:0]  t_b, t_e;
   logic        t_start, t_stop;
   initial begin
      forever begin
         @(negedge clk);
         if (uart_txd_o === 1'b0 && rst_n === 1'b1) begin
            t_bp = 16 * (cur_div + 1);
            repeat (t_bp / 2 - 1) @(negedge clk);
            t_start = uart_txd_o;
            for (int i = 0; i < 8; i++) begin
               repeat (t_bp) @(negedge clk);
               t_b[i] = uart_txd_o;
            end
            repeat (t_bp) @(negedge clk);
            t_stop = uart_txd_o;
            tx_frames++;
            if (tx_exp.size() == 0) begin
               fail("tx_unexpected_frame", int'(t_b), -1);
            end else begin
               t_e = tx_exp.pop_front();
               total++;
               if (t_b !== t_e || t_start !== 1'b0 || t_stop !== 1'b1) begin
                  bad++;
                  $display("FAIL tx_frame got=%h start=%b stop=%b required=%h", t_b, t_start, t_stop, t_e);
               end
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, low, f0;
      logic [7:0] b;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", int'(uart_txd_o), 1);
      check("rst_irq", int'(irq_o), 0);
      check("rst_ack", int'(wb_ack_o), 0);
      check("rst_dat", int'(wb_dat_o), 0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(A_STAT, 16'h0008, 16'hFFFF);
      rd(A_DIV, 16'd26, 16'hFFFF);
      rd(A_CTRL, 16'h0000, 16'hFFFF);
      rd(A_DATA, 16'h0000, 16'hFFFF);

      // Single byte at DIV=0: each bit exactly 16 clocks.
      set_div(0);
      tx_byte(8'hA5);
      n = 0;
      while (uart_txd_o !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) fail("tx_start_seen", n, 0);
      low = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (uart_txd_o !== 1'b0) break;
         low++;
      end
      check("tx_start_len", low, 16);
      wait_tx_done(400);
      rd(A_STAT, 16'h0008, 16'h000C);

      // Randomized TX bursts at random divisors.
      for (int r = 0; r < 3; r++) begin
         set_div(int'($urandom_range(0, 3)));
         n = int'($urandom_range(1, 5));
         for (int k = 0; k < n; k++) tx_byte(8'($urandom));
         wait_tx_done(n * 10 * 16 * (cur_div + 1) + 200);
         rd(A_STAT, 16'h0008, 16'h000C);
      end

      // TX overflow: one byte in the shifter plus DEPTH queued, the rest dropped.
      set_div(6);
      f0 = tx_frames;
      for (int k = 0; k < DEPTH + 2; k++) begin
         b = 8'($urandom);
         wr(A_DATA, {8'h00, b});
         if (k < DEPTH + 1) tx_exp.push_back(b);
      end
      rd(A_STAT, 16'h0004, 16'h000C);
      wait_tx_done((DEPTH + 2) * 10 * 16 * 7);
      rd(A_STAT, 16'h0008, 16'h000C);
      check("tx_frame_count", tx_frames - f0, DEPTH + 1);

      // RX single byte with interrupt enabled.
      set_div(3);
      wr(A_CTRL, 16'h0001);
      rx_send(8'h3C, 1'b1);
      rd(A_STAT, rx_stat(), 16'h0013);
      check("irq_set", int'(irq_o), 1);
      rd_data();
      rd(A_STAT, rx_stat(), 16'h0013);
      check("irq_clr", int'(irq_o), 0);
      wr(A_CTRL, 16'h0003);
`ifdef WB_UART_LOOPBACK_EN
      rd(A_CTRL, 16'h0003, 16'hFFFF);
`else
      rd(A_CTRL, 16'h0001, 16'hFFFF);
`endif
      wr(A_CTRL, 16'h0000);

      // Random RX frames, one with a framing error, then a short glitch.
      n = int'($urandom_range(0, 4));
      for (int k = 0; k < 5; k++) rx_send(8'($urandom), k != n);
      rd(A_STAT, rx_stat(), 16'h0013);
      for (int k = 0; k < 5; k++) rd_data();
      rxd = 1'b0;
      repeat (4 * (cur_div + 1)) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * 16 * (cur_div + 1)) @(negedge clk);
      rd(A_STAT, rx_stat(), 16'h0013);

      // RX overflow: DEPTH+1 frames with no reads.
      for (int k = 0; k < DEPTH + 1; k++) rx_send(8'($urandom), 1'b1);
      rd(A_STAT, rx_stat(), 16'h0013);
      for (int k = 0; k < DEPTH + 1; k++) rd_data();
      rd(A_STAT, rx_stat(), 16'h0013);
      wr(A_STAT, 16'h0010);
      rx_ovr = 1'b0;
      rd(A_STAT, rx_stat(), 16'h0013);

`ifdef WB_UART_LOOPBACK_EN
      wr(A_CTRL, 16'h0002);
      wr(A_DATA, 16'h005A);
      rx_model.push_back(8'h5A);
      low = 0;
      for (int i = 0; i < 12 * 16 * (cur_div + 1); i++) begin
         @(negedge clk);
         if (uart_txd_o !== 1'b1) low++;
      end
      check("lb_txd_quiet", low, 0);
      rd_data();
      wr(A_CTRL, 16'h0000);
`endif

      repeat (10) @(negedge clk);
      check("rd_queue_left", rd_exp_q.size(), 0);
      check("tx_queue_left", tx_exp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
